// File: rtl/conv_nxn_stream.sv
// Streaming N x N 2-D convolver: shifts kernel/image columns in, two-stage multiply/sum pipeline.
// Optional CONV_ROUND_EN: round half-up before truncation, saturating on positive overflow.
module conv_nxn_stream #(
  parameter int BIT_LEN   = 8,
  parameter int M_LEN     = 3,
  parameter int CONV_LEN  = 20,
  parameter int CONV_LPOS = 13
) (
  input  logic                       CLK100MHZ,
  input  logic                       i_reset,
  input  logic [M_LEN*BIT_LEN-1:0]   i_data,
  input  logic                       i_selecK_I,
  input  logic                       i_sof,
  input  logic                       i_valid,
  output logic                       o_ready,
  output logic [CONV_LPOS-1:0]       o_data,
  output logic                       o_valid,
  input  logic                       i_ready
);

  localparam int FW  = $clog2(M_LEN + 1);
  localparam int PW  = 2 * BIT_LEN;
  localparam int NT  = M_LEN * M_LEN;
  localparam int CTR = M_LEN / 2;

  logic signed [BIT_LEN-1:0]  kernel_q [M_LEN][M_LEN];
  logic signed [BIT_LEN-1:0]  image_q  [M_LEN][M_LEN];
  logic        [FW-1:0]       fill_q, fill_d;
  logic signed [PW-1:0]       prod_q [NT];
  logic signed [PW-1:0]       prod_d [NT];
  logic signed [CONV_LEN-1:0] sum_raw, sum_d, sum_q;
  logic                       win_valid_q, s1_valid_q, valid_q;
  logic                       en, accept, k_acc, img_acc, launch;

  assign en      = !valid_q || i_ready;
  assign accept  = i_valid && en;
  assign k_acc   = accept && !i_selecK_I;
  assign img_acc = accept && i_selecK_I;
  assign o_ready = en;
  assign o_valid = valid_q;

  always_comb begin
    fill_d = fill_q;
    if (k_acc) begin
      fill_d = '0;
    end else if (img_acc) begin
      if (i_sof) begin
        fill_d = FW'(1);
      end else if (fill_q == FW'(M_LEN)) begin
        fill_d = fill_q;
      end else begin
        fill_d = fill_q + FW'(1);
      end
    end
  end

  assign launch = img_acc && (fill_d == FW'(M_LEN));

  // Column 0 is the oldest; a new column always enters at M_LEN-1.
  always_ff @(posedge CLK100MHZ or posedge i_reset) begin
    if (i_reset) begin
      for (int c = 0; c < M_LEN; c++) begin
        for (int r = 0; r < M_LEN; r++) begin
          kernel_q[c][r] <= '0;
          image_q[c][r]  <= '0;
        end
      end
      kernel_q[CTR][CTR] <= BIT_LEN'(1);
      fill_q <= '0;
    end else begin
      if (k_acc) begin
        for (int c = 0; c < M_LEN - 1; c++) begin
          for (int r = 0; r < M_LEN; r++) begin
            kernel_q[c][r] <= kernel_q[c+1][r];
          end
        end
        for (int r = 0; r < M_LEN; r++) begin
          kernel_q[M_LEN-1][r] <= i_data[r*BIT_LEN +: BIT_LEN];
        end
      end
      if (img_acc) begin
        for (int c = 0; c < M_LEN - 1; c++) begin
          for (int r = 0; r < M_LEN; r++) begin
            image_q[c][r] <= image_q[c+1][r];
          end
        end
        for (int r = 0; r < M_LEN; r++) begin
          image_q[M_LEN-1][r] <= i_data[r*BIT_LEN +: BIT_LEN];
        end
      end
      fill_q <= fill_d;
    end
  end

  always_comb begin
    for (int c = 0; c < M_LEN; c++) begin
      for (int r = 0; r < M_LEN; r++) begin
        prod_d[c*M_LEN + r] = PW'(kernel_q[c][r]) * PW'(image_q[c][r]);
      end
    end
  end

  always_comb begin
    sum_raw = '0;
    for (int i = 0; i < NT; i++) begin
      sum_raw = sum_raw + CONV_LEN'(prod_q[i]);
    end
  end

`ifdef CONV_ROUND_EN
  localparam logic signed [CONV_LEN-1:0] RndBias = CONV_LEN'(1) << (CONV_LEN - CONV_LPOS - 1);
  logic signed [CONV_LEN-1:0] sum_rnd;

  always_comb begin
    sum_rnd = sum_raw + RndBias;
    if (!sum_raw[CONV_LEN-1] && sum_rnd[CONV_LEN-1]) begin
      sum_d = {1'b0, {(CONV_LEN-1){1'b1}}};
    end else begin
      sum_d = sum_rnd;
    end
  end
`else
  always_comb begin
    sum_d = sum_raw;
  end
`endif

  // A launch flag trails the window update so products see the completed window.
  always_ff @(posedge CLK100MHZ or posedge i_reset) begin
    if (i_reset) begin
      win_valid_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      valid_q     <= 1'b0;
      sum_q       <= '0;
      for (int i = 0; i < NT; i++) begin
        prod_q[i] <= '0;
      end
    end else if (en) begin
      win_valid_q <= launch;
      s1_valid_q  <= win_valid_q;
      valid_q     <= s1_valid_q;
      sum_q       <= sum_d;
      for (int i = 0; i < NT; i++) begin
        prod_q[i] <= prod_d[i];
      end
    end
  end

  assign o_data = {~sum_q[CONV_LEN-1], sum_q[CONV_LEN-2 -: CONV_LPOS-1]};

  logic unused_lsbs;
  assign unused_lsbs = ^sum_q[CONV_LEN-CONV_LPOS-1:0];

endmodule

// File: tb/tb_conv_nxn_stream.sv
// Self-checking bench for conv_nxn_stream: directed cases plus randomized traffic against
// an arithmetic reference model of kernel, window, fill and a 3-slot result pipeline.
module tb_conv_nxn_stream;

  localparam int BIT_LEN   = 8;
  localparam int M_LEN     = 3;
  localparam int CONV_LEN  = 20;
  localparam int CONV_LPOS = 13;
  localparam int DW        = M_LEN * BIT_LEN;
  localparam int SHIFT     = CONV_LEN - CONV_LPOS;
  localparam int CTR       = M_LEN / 2;

`ifdef CONV_ROUND_EN
  localparam logic [31:0] ExpA = 32'h1040;
  localparam logic [31:0] ExpC = 32'h1001;
`else
  localparam logic [31:0] ExpA = 32'h103F;
  localparam logic [31:0] ExpC = 32'h1000;
`endif
  localparam logic [31:0] ExpB = 32'h0F81;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [DW-1:0]        col_data;
  logic                 col_sel, col_sof, col_valid;
  logic                 dut_ready;
  logic [CONV_LPOS-1:0] res_data;
  logic                 res_valid;
  logic                 res_ready;

  always #5 clk = ~clk;

  conv_nxn_stream #(
    .BIT_LEN  (BIT_LEN),
    .M_LEN    (M_LEN),
    .CONV_LEN (CONV_LEN),
    .CONV_LPOS(CONV_LPOS)
  ) dut (
    .CLK100MHZ (clk),
    .i_reset   (rst),
    .i_data    (col_data),
    .i_selecK_I(col_sel),
    .i_sof     (col_sof),
    .i_valid   (col_valid),
    .o_ready   (dut_ready),
    .o_data    (res_data),
    .o_valid   (res_valid),
    .i_ready   (res_ready)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int          km [M_LEN][M_LEN];
  int          wm [M_LEN][M_LEN];
  int          fill;
  bit          pv [3];
  logic [31:0] pd [3];
  int          n_out;

  function automatic int elem(input logic [DW-1:0] d, input int r);
    logic signed [BIT_LEN-1:0] b;
    b = d[r*BIT_LEN +: BIT_LEN];
    return int'(b);
  endfunction

  function automatic logic [31:0] map_sum(input int s);
    int t;
    int q;
    t = s;
`ifdef CONV_ROUND_EN
    t = t + (1 << (SHIFT - 1));
    if (t > (1 << (CONV_LEN - 1)) - 1) t = (1 << (CONV_LEN - 1)) - 1;
`endif
    q = t >>> SHIFT;
    return (q & ((1 << CONV_LPOS) - 1)) ^ (1 << (CONV_LPOS - 1));
  endfunction

  task automatic model_reset();
    for (int c = 0; c < M_LEN; c++) begin
      for (int r = 0; r < M_LEN; r++) begin
        km[c][r] = 0;
        wm[c][r] = 0;
      end
    end
    km[CTR][CTR] = 1;
    fill = 0;
    for (int i = 0; i < 3; i++) begin
      pv[i] = 1'b0;
      pd[i] = '0;
    end
  endtask

  // Entered just after a falling edge with inputs driven; returns after the next falling edge.
  task automatic cycle();
    bit en_m;
    bit launch;
    int res;
    #1;
    en_m = !pv[2] || res_ready;
    check_eq("o_valid", res_valid, pv[2]);
    check_eq("o_ready", dut_ready, en_m);
    if (pv[2]) check_eq("o_data", res_data, pd[2]);
    if (pv[2] && res_ready) n_out++;
    if (en_m) begin
      launch = 1'b0;
      res = 0;
      if (col_valid) begin
        if (!col_sel) begin
          for (int c = 0; c < M_LEN - 1; c++)
            for (int r = 0; r < M_LEN; r++) km[c][r] = km[c+1][r];
          for (int r = 0; r < M_LEN; r++) km[M_LEN-1][r] = elem(col_data, r);
          fill = 0;
        end else begin
          for (int c = 0; c < M_LEN - 1; c++)
            for (int r = 0; r < M_LEN; r++) wm[c][r] = wm[c+1][r];
          for (int r = 0; r < M_LEN; r++) wm[M_LEN-1][r] = elem(col_data, r);
          fill = col_sof ? 1 : ((fill < M_LEN) ? fill + 1 : M_LEN);
          launch = (fill == M_LEN);
          for (int c = 0; c < M_LEN; c++)
            for (int r = 0; r < M_LEN; r++) res += km[c][r] * wm[c][r];
        end
      end
      pv[2] = pv[1]; pd[2] = pd[1];
      pv[1] = pv[0]; pd[1] = pd[0];
      pv[0] = launch; pd[0] = map_sum(res);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit sel, input bit sof, input bit valid, input logic [DW-1:0] d);
    col_sel   = sel;
    col_sof   = sof;
    col_valid = valid;
    col_data  = d;
    cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, '0);
  endtask

  // Asserted between edges; outputs must clear without waiting for a clock.
  task automatic pulse_reset();
    col_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check_eq("rst_o_valid", res_valid, 0);
    check_eq("rst_o_data", res_data, 32'h1000);
    check_eq("rst_o_ready", dut_ready, 1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  int base;
  int tries;
  logic [CONV_LPOS-1:0] held;

  initial begin
    rst = 1'b0; col_data = '0; col_sel = 1'b0; col_sof = 1'b0; col_valid = 1'b0;
    res_ready = 1'b1; n_out = 0;
    model_reset();
    @(negedge clk);
    pulse_reset();

    // Kernel centre 0x40, centre pixel 0x7F
    drive(1'b0, 1'b0, 1'b1, 24'h000000);
    drive(1'b0, 1'b0, 1'b1, 24'h004000);
    drive(1'b0, 1'b0, 1'b1, 24'h000000);
    drive(1'b1, 1'b1, 1'b1, 24'h007F00);
    drive(1'b1, 1'b0, 1'b1, 24'h007F00);
    drive(1'b1, 1'b0, 1'b1, 24'h007F00);
    idle(2);
    check_eq("dirA_valid", res_valid, 1);
    check_eq("dirA_data", res_data, ExpA);
    idle(1);

    // Kernel centre 0x7F, centre pixel 0x80
    drive(1'b0, 1'b0, 1'b1, 24'h000000);
    drive(1'b0, 1'b0, 1'b1, 24'h007F00);
    drive(1'b0, 1'b0, 1'b1, 24'h000000);
    drive(1'b1, 1'b1, 1'b1, 24'h008000);
    drive(1'b1, 1'b0, 1'b1, 24'h008000);
    drive(1'b1, 1'b0, 1'b1, 24'h008000);
    idle(2);
    check_eq("dirB_valid", res_valid, 1);
    check_eq("dirB_data", res_data, ExpB);
    idle(1);

    // Identity kernel after reset
    pulse_reset();
    drive(1'b1, 1'b1, 1'b1, 24'h007F00);
    drive(1'b1, 1'b0, 1'b1, 24'h007F00);
    drive(1'b1, 1'b0, 1'b1, 24'h007F00);
    idle(2);
    check_eq("ident_valid", res_valid, 1);
    check_eq("ident_data", res_data, ExpC);
    idle(1);

    // Steady stream of 8 columns with a random kernel
    for (int i = 0; i < M_LEN; i++) drive(1'b0, 1'b0, 1'b1, DW'($urandom()));
    base = n_out;
    for (int i = 0; i < 8; i++) drive(1'b1, (i == 0), 1'b1, DW'($urandom()));
    idle(3);
    check_eq("stream_count", n_out - base, 6);

    // Backpressure: hold i_ready low for 3 cycles with i_valid high
    drive(1'b1, 1'b1, 1'b1, DW'($urandom()));
    tries = 0;
    while (!res_valid && tries < 10) begin
      drive(1'b1, 1'b0, 1'b1, DW'($urandom()));
      tries++;
    end
    check_eq("stall_reach", res_valid, 1);
    held = res_data;
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, DW'($urandom()));
      check_eq("stall_hold", res_data, held);
      check_eq("stall_ready", dut_ready, 0);
    end
    res_ready = 1'b1;
    idle(4);

    // Row restart on 5th column, kernel load mid-row, reset with a result in flight
    pulse_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, (i == 0), 1'b1, DW'($urandom()));
    base = n_out;
    for (int i = 0; i < 3; i++) drive(1'b1, (i == 0), 1'b1, DW'($urandom()));
    idle(3);
    check_eq("sof_restart_count", n_out - base, 3);
    drive(1'b1, 1'b0, 1'b1, DW'($urandom()));
    drive(1'b0, 1'b0, 1'b1, DW'($urandom()));
    base = n_out;
    for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 1'b1, DW'($urandom()));
    idle(3);
    check_eq("kload_restart_count", n_out - base, 1);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, DW'($urandom()));
    pulse_reset();
    idle(4);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) pulse_reset();
      res_ready = ($urandom_range(0, 3) != 0);
      drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 9) < 7), DW'($urandom()));
    end
    res_ready = 1'b1;
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
